// File: rtl/rto_write_arbiter.sv
// Round-robin arbiter sharing one RTOB core write port among NUM_REQ producers,
// with flush sequencing and sticky timestamp-order error detection.
module rto_write_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ID_LEN       = 2,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*128-1:0]   req_data,
    input  logic                     flush_req,
    input  logic                     rto_core_full,
    output logic                     rto_core_write,
    output logic [127:0]             rto_core_fifo_din,
    output logic                     rto_core_flush,
    output logic [ID_LEN-1:0]        grant_id,
    output logic                     busy,
    output logic                     ts_order_error,
    output logic [ID_LEN-1:0]        err_req_id,
    input  logic                     error_clear
);

    localparam int PAD   = 1 << ID_LEN;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   flush_cnt;
    logic               flush_last;
    logic [ID_LEN-1:0]  rr_ptr;
    logic [ID_LEN-1:0]  ptr_next;
    logic [63:0]        last_ts;

    logic [PAD-1:0]     valid_ext;
    logic [PAD-1:0]     ready_ext;
    logic [127:0]       data_arr [PAD];
    logic               grant_found;
    logic [ID_LEN-1:0]  grant_idx;
    logic [ID_LEN-1:0]  cand;
    logic [127:0]       sel_data;
    logic               accept;
    logic               ts_back;

    // Padding to a power of two keeps every index exactly ID_LEN bits wide
    assign valid_ext = PAD'(req_valid);

    for (genvar gi = 0; gi < PAD; gi++) begin : g_unpack
        if (gi < NUM_REQ) begin : g_real
            assign data_arr[gi] = req_data[gi*128 +: 128];
        end else begin : g_pad
            assign data_arr[gi] = '0;
        end
    end

    // Search for the first valid requester starting at rr_ptr, wrapping at NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_LEN'((int'(rr_ptr) + k) % NUM_REQ);
            if (!grant_found && valid_ext[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_data   = data_arr[grant_idx];
    assign ts_back    = sel_data[127:64] < last_ts;
    assign accept     = s_axi_aresetn && (state == ST_RUN) && !flush_req
                        && !rto_core_full && grant_found;
    assign ready_ext  = accept ? (PAD'(1) << grant_idx) : '0;
    assign req_ready  = ready_ext[NUM_REQ-1:0];
    assign ptr_next   = (grant_idx == ID_LEN'(NUM_REQ - 1)) ? '0 : grant_idx + ID_LEN'(1);
    assign flush_last = (flush_cnt == CNT_W'(FLUSH_CYCLES - 1));

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (flush_req)  state_next = ST_FLUSH;
            ST_FLUSH: if (flush_last) state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state          <= ST_RUN;
            flush_cnt      <= '0;
            rto_core_flush <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            flush_cnt      <= (state == ST_FLUSH) ? flush_cnt + CNT_W'(1) : '0;
            rto_core_flush <= (state_next == ST_FLUSH);
            busy           <= (state_next == ST_FLUSH);
        end
    end

    // Write path; flushing discards arbitration history so the next stream starts fresh
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            rto_core_write    <= 1'b0;
            rto_core_fifo_din <= '0;
            grant_id          <= '0;
            rr_ptr            <= '0;
            last_ts           <= '0;
        end else begin
            rto_core_write <= accept;
            if (accept) begin
                rto_core_fifo_din <= sel_data;
                grant_id          <= grant_idx;
                rr_ptr            <= ptr_next;
                last_ts           <= sel_data[127:64];
            end else if (state == ST_FLUSH) begin
                rr_ptr  <= '0;
                last_ts <= '0;
            end
        end
    end

    // Only the first offender is recorded; a new error wins over a clear
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            ts_order_error <= 1'b0;
            err_req_id     <= '0;
        end else if (accept && ts_back) begin
            ts_order_error <= 1'b1;
            if (!ts_order_error) begin
                err_req_id <= grant_idx;
            end
        end else if (error_clear) begin
            ts_order_error <= 1'b0;
        end
    end

endmodule

// File: doc/rto_write_arbiter.md
Name: rto_write_arbiter

Overview:
- Shares one RTOB core write port (write / 128-bit fifo_din / full / flush) among NUM_REQ independent producers, e.g. several AXI2FIFO front-ends or on-chip sequencers feeding one TTL bank.
- Round-robin grant, registered output, flush sequencing and timestamp-order checking.
- Sits between the producers and the RTOB core.
- Entry format: din[127:64] = timestamp, din[63:0] = payload.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_LEN, 2, width of grant index, equals ceil(log2(NUM_REQ))
FLUSH_CYCLES, 4, cycles rto_core_flush is held high per flush request (>=1)

Ports:
s_axi_aclk  in  1  sole clock
s_axi_aresetn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester entry valid
req_ready  out  NUM_REQ  per-requester accept, one-hot or zero, combinational
req_data  in  NUM_REQ*128  entries, requester i at [128*i+127:128*i]
flush_req  in  1  single-cycle flush request
rto_core_full  in  1  RTOB FIFO full, asserted with one entry of slack
rto_core_write  out  1  registered write strobe to RTOB
rto_core_fifo_din  out  128  registered entry
rto_core_flush  out  1  registered flush to RTOB
grant_id  out  ID_LEN  requester index of the current rto_core_write
busy  out  1  high while in FLUSH state
ts_order_error  out  1  sticky timestamp-order error
err_req_id  out  ID_LEN  requester that caused the first error
error_clear  in  1  clears ts_order_error

Behaviour:
- Reset values (asynchronous):
  - All outputs 0, state RUN, rr_ptr 0, last_ts 0.
  - req_ready is 0 during reset.
- FSM state RUN:
  - If flush_req=1: no grant this cycle; go to FLUSH.
  - Otherwise, if rto_core_full=0: grant the first requester with req_valid=1, searching from rr_ptr upward with modulo NUM_REQ wrap.
  - For that granted requester g: req_ready[g]=1 in the same cycle and the entry is accepted.
  - At the next edge: rr_ptr <= (g+1) mod NUM_REQ.
  - If rto_core_full=1 or no request is valid: req_ready=0 and rr_ptr is held.
- FSM state FLUSH:
  - rto_core_flush=1 and busy=1 for exactly FLUSH_CYCLES cycles, starting the cycle after flush_req.
  - req_ready=0 and rto_core_write=0 throughout.
  - last_ts <= 0 and rr_ptr <= 0.
  - Then return to RUN.
  - flush_req while in FLUSH is ignored.
- Output latency: an entry accepted at edge T appears at T+1:
  - rto_core_write=1, rto_core_fifo_din=entry, grant_id=g.
  - rto_core_write is otherwise 0.
- Full-port throughput is 1 entry/cycle. The arbiter does not re-check full after acceptance (one-slot slack is the RTOB's responsibility).
- Flush vs. in-flight write:
  - An entry accepted at T-1 still writes at T.
  - flush_req sampled at T yields rto_core_flush=1 from T+1, so the prior write is flushed.
  - Write and flush are never high in the same cycle.
- Timestamp check on each accept:
  - If ts < last_ts (unsigned 64-bit), then ts_order_error <= 1. err_req_id <= g, but only if ts_order_error was 0 (the first error is retained).
  - The entry is still forwarded.
  - last_ts <= ts on every accept. Equal timestamps are legal.
- error_clear=1 clears ts_order_error. If set and clear occur in the same cycle, set wins.
- req_data of non-granted requesters is ignored. Producers must hold valid/data until ready; the arbiter does not depend on that.

Test Plan:
1. All 4 requesters valid continuously with ts = 10, 20, 30, ... per accept → grants 0,1,2,3,0,... one per cycle; rto_core_write high every cycle from the cycle after the first accept; no error.
2. Only requester 2 valid, 5 entries → 5 consecutive writes with grant_id=2; rr_ptr wraps to 3 each time; no stall.
3. rto_core_full=1 for 3 cycles mid-stream → req_ready=0 and no writes for those cycles (after the one in-flight write); resume with the next requester in round-robin order, no entry lost or duplicated.
4. Accept entry with ts=100, then pulse flush_req the next cycle with all requesters valid → write(ts=100) issues, then rto_core_flush=1 for 4 cycles with busy=1 and no req_ready; after that a ts=5 entry is accepted without error and grant restarts at requester 0.
5. Requester 1 sends ts=50, then requester 3 sends ts=40 → both written, ts_order_error=1, err_req_id=3; later ts=30 from requester 0 leaves err_req_id=3; error_clear=1 with no new error → ts_order_error=0.
6. Deassert s_axi_aresetn asynchronously mid-burst and mid-flush → all outputs 0 immediately; after release, state RUN, first grant to requester 0, last_ts=0.
